// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline control for the 5-stage RV32I core.
// It drives the stage-register write enables and nop inputs, and the PC write enable.
// It handles load-use stalls, EX-stage redirects and a drain-then-halt sequence.
// It also produces the EX forwarding selects and two wrapping performance counters.
module hazard_ctrl #(
    parameter int LOAD_USE_STALL = 1,   // bubble cycles per load-use hazard (1..7)
    parameter int DRAIN_CYCLES   = 3    // cycles after halt before o_halted (1..7)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [4:0]  i_id_rs1,
    input  logic [4:0]  i_id_rs2,
    input  logic        i_id_uses_rs1,
    input  logic        i_id_uses_rs2,
    input  logic        i_id_halt,
    input  logic [4:0]  i_ex_rs1,
    input  logic [4:0]  i_ex_rs2,
    input  logic [4:0]  i_ex_rd,
    input  logic        i_ex_we_reg,
    input  logic        i_ex_is_load,
    input  logic        i_redirect_ex,
    input  logic [4:0]  i_mem_rd,
    input  logic        i_mem_we_reg,
    input  logic [4:0]  i_wb_rd,
    input  logic        i_wb_we_reg,
    output logic        o_pc_we,
    output logic        o_if_id_we,
    output logic        o_if_id_nop,
    output logic        o_id_ex_we,
    output logic        o_id_ex_nop,
    output logic        o_ex_mem_nop,
    output logic [1:0]  o_fwd_a_sel,
    output logic [1:0]  o_fwd_b_sel,
    output logic        o_halted,
    output logic [31:0] o_stall_cycles,
    output logic [31:0] o_flush_count
);

    typedef enum logic [1:0] {S_RUN, S_LOAD_STALL, S_DRAIN, S_HALTED} state_t;

    // The hazard cycle itself is the first bubble, so LOAD_STALL only covers the remaining ones.
    localparam int          LU_RELOAD_I  = (LOAD_USE_STALL > 1) ? LOAD_USE_STALL - 2 : 0;
    localparam logic [2:0]  LU_RELOAD    = 3'(LU_RELOAD_I);
    localparam logic [2:0]  DRAIN_RELOAD = 3'(DRAIN_CYCLES - 1);

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_cnt, w_cnt_nxt;
    logic        r_halted;
    logic [31:0] r_stall_cycles, r_flush_count;
    logic        w_lu_hazard, w_stall_inc, w_flush_inc, w_halt_set;

    assign w_lu_hazard = i_ex_is_load & i_ex_we_reg & (i_ex_rd != 5'd0) &
                         ((i_id_uses_rs1 & (i_id_rs1 == i_ex_rd)) |
                          (i_id_uses_rs2 & (i_id_rs2 == i_ex_rd)));

    // The younger MEM result wins over WB; x0 is never forwarded.
    assign o_fwd_a_sel = i_rst ? 2'b00 :
                         (i_mem_we_reg && i_mem_rd != 5'd0 && i_mem_rd == i_ex_rs1) ? 2'b01 :
                         (i_wb_we_reg  && i_wb_rd  != 5'd0 && i_wb_rd  == i_ex_rs1) ? 2'b10 : 2'b00;
    assign o_fwd_b_sel = i_rst ? 2'b00 :
                         (i_mem_we_reg && i_mem_rd != 5'd0 && i_mem_rd == i_ex_rs2) ? 2'b01 :
                         (i_wb_we_reg  && i_wb_rd  != 5'd0 && i_wb_rd  == i_ex_rs2) ? 2'b10 : 2'b00;

    assign o_halted       = r_halted;
    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_count  = r_flush_count;

    // Next-state, counter-event and stage-control decode
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_stall_inc  = 1'b0;
        w_flush_inc  = 1'b0;
        w_halt_set   = 1'b0;
        o_pc_we      = 1'b1;
        o_if_id_we   = 1'b1;
        o_if_id_nop  = 1'b0;
        o_id_ex_we   = 1'b1;
        o_id_ex_nop  = 1'b0;
        o_ex_mem_nop = 1'b0;
        case (r_state)
            S_RUN: begin
                if (i_redirect_ex) begin
                    o_if_id_nop = 1'b1;
                    o_id_ex_nop = 1'b1;
                    w_flush_inc = 1'b1;
                end else if (w_lu_hazard) begin
                    o_pc_we     = 1'b0;
                    o_if_id_we  = 1'b0;
                    o_id_ex_nop = 1'b1;
                    w_stall_inc = 1'b1;
                    if (LOAD_USE_STALL > 1) begin
                        w_state_nxt = S_LOAD_STALL;
                        w_cnt_nxt   = LU_RELOAD;
                    end
                end else if (i_id_halt) begin
                    o_pc_we     = 1'b0;
                    o_if_id_we  = 1'b0;
                    o_id_ex_nop = 1'b1;
                    w_state_nxt = S_DRAIN;
                    w_cnt_nxt   = DRAIN_RELOAD;
                end
            end
            S_LOAD_STALL: begin
                if (i_redirect_ex) begin
                    o_if_id_nop = 1'b1;
                    o_id_ex_nop = 1'b1;
                    w_flush_inc = 1'b1;
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = 3'd0;
                end else begin
                    o_pc_we     = 1'b0;
                    o_if_id_we  = 1'b0;
                    o_id_ex_nop = 1'b1;
                    w_stall_inc = 1'b1;
                    if (r_cnt == 3'd0) w_state_nxt = S_RUN;
                    else               w_cnt_nxt   = r_cnt - 3'd1;
                end
            end
            S_DRAIN: begin
                o_pc_we     = 1'b0;
                o_if_id_we  = 1'b0;
                o_id_ex_nop = 1'b1;
                if (r_cnt == 3'd0) begin
                    w_state_nxt = S_HALTED;
                    w_halt_set  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            default: begin
                o_pc_we      = 1'b0;
                o_if_id_we   = 1'b0;
                o_id_ex_nop  = 1'b1;
                o_ex_mem_nop = 1'b1;
            end
        endcase
        // Reset holds the PC and flushes every stage register.
        if (i_rst) begin
            o_pc_we      = 1'b0;
            o_if_id_we   = 1'b1;
            o_if_id_nop  = 1'b1;
            o_id_ex_we   = 1'b1;
            o_id_ex_nop  = 1'b1;
            o_ex_mem_nop = 1'b1;
        end
    end

    // State, down-counter, halted flag and performance counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_RUN;
            r_cnt          <= 3'd0;
            r_halted       <= 1'b0;
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 32'd0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_halted       <= r_halted | w_halt_set;
            r_stall_cycles <= r_stall_cycles + {31'd0, w_stall_inc};
            r_flush_count  <= r_flush_count + {31'd0, w_flush_inc};
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl.
// u_dut uses LOAD_USE_STALL=1 and u_dut3 uses LOAD_USE_STALL=3; both instances share the stimulus.
module tb_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic        id_uses_rs1, id_uses_rs2, id_halt, ex_we_reg, ex_is_load;
    logic        redirect_ex, mem_we_reg, wb_we_reg;

    logic        pc_we, if_id_we, if_id_nop, id_ex_we, id_ex_nop, ex_mem_nop, halted;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cnt, flush_cnt;
    logic        pc_we3, if_id_we3, if_id_nop3, id_ex_we3, id_ex_nop3, ex_mem_nop3, halted3;
    logic [1:0]  fwd_a3, fwd_b3;
    logic [31:0] stall_cnt3, flush_cnt3;

    int n_tests = 0;
    int n_fail  = 0;
    int stalls1, stalls3;

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_USE_STALL(1), .DRAIN_CYCLES(3)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_uses_rs1(id_uses_rs1), .i_id_uses_rs2(id_uses_rs2), .i_id_halt(id_halt),
        .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2), .i_ex_rd(ex_rd), .i_ex_we_reg(ex_we_reg),
        .i_ex_is_load(ex_is_load), .i_redirect_ex(redirect_ex), .i_mem_rd(mem_rd),
        .i_mem_we_reg(mem_we_reg), .i_wb_rd(wb_rd), .i_wb_we_reg(wb_we_reg),
        .o_pc_we(pc_we), .o_if_id_we(if_id_we), .o_if_id_nop(if_id_nop), .o_id_ex_we(id_ex_we),
        .o_id_ex_nop(id_ex_nop), .o_ex_mem_nop(ex_mem_nop), .o_fwd_a_sel(fwd_a),
        .o_fwd_b_sel(fwd_b), .o_halted(halted), .o_stall_cycles(stall_cnt),
        .o_flush_count(flush_cnt));

    hazard_ctrl #(.LOAD_USE_STALL(3), .DRAIN_CYCLES(3)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_uses_rs1(id_uses_rs1), .i_id_uses_rs2(id_uses_rs2), .i_id_halt(id_halt),
        .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2), .i_ex_rd(ex_rd), .i_ex_we_reg(ex_we_reg),
        .i_ex_is_load(ex_is_load), .i_redirect_ex(redirect_ex), .i_mem_rd(mem_rd),
        .i_mem_we_reg(mem_we_reg), .i_wb_rd(wb_rd), .i_wb_we_reg(wb_we_reg),
        .o_pc_we(pc_we3), .o_if_id_we(if_id_we3), .o_if_id_nop(if_id_nop3), .o_id_ex_we(id_ex_we3),
        .o_id_ex_nop(id_ex_nop3), .o_ex_mem_nop(ex_mem_nop3), .o_fwd_a_sel(fwd_a3),
        .o_fwd_b_sel(fwd_b3), .o_halted(halted3), .o_stall_cycles(stall_cnt3),
        .o_flush_count(flush_cnt3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply new inputs one clock after the previous negedge, then let them settle.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_halt = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_we_reg = 0; ex_is_load = 0;
        redirect_ex = 0; mem_rd = 0; mem_we_reg = 0; wb_rd = 0; wb_we_reg = 0;
    endtask

    task automatic load_use_inputs();
        ex_is_load = 1; ex_we_reg = 1; ex_rd = 5; id_uses_rs1 = 1; id_rs1 = 5; id_rs2 = 1;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        tick(); tick(); #1;
        chk("rst_pc_we", {31'd0, pc_we}, 0);
        chk("rst_if_id_nop", {31'd0, if_id_nop}, 1);
        chk("rst_id_ex_nop", {31'd0, id_ex_nop}, 1);
        chk("rst_ex_mem_nop", {31'd0, ex_mem_nop}, 1);
        chk("rst_halted", {31'd0, halted}, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_flush", flush_cnt, 0);

        // Idle run
        rst = 0;
        tick(); #1;
        chk("idle_pc_we", {31'd0, pc_we}, 1);
        chk("idle_nops", {29'd0, if_id_nop, id_ex_nop, ex_mem_nop}, 0);
        chk("idle_we", {30'd0, if_id_we, id_ex_we}, 2'b11);
        chk("idle_fwd", {28'd0, fwd_a, fwd_b}, 0);
        chk("idle_halted", {31'd0, halted}, 0);

        // Load-use hazard: one bubble vs three bubbles
        load_use_inputs(); #1;
        chk("lu_pc_we", {31'd0, pc_we}, 0);
        chk("lu_if_id_we", {31'd0, if_id_we}, 0);
        chk("lu_id_ex", {30'd0, id_ex_we, id_ex_nop}, 2'b11);
        chk("lu3_pc_we", {31'd0, pc_we3}, 0);
        stalls1 = 1; stalls3 = 1;
        tick(); idle_inputs();
        for (int i = 0; i < 6; i++) begin
            #1;
            if (!pc_we)  stalls1++;
            if (!pc_we3) stalls3++;
            tick();
        end
        #1;
        chk("lu1_stall_len", stalls1, 1);
        chk("lu3_stall_len", stalls3, 3);
        chk("lu1_stall_cnt", stall_cnt, 1);
        chk("lu3_stall_cnt", stall_cnt3, 3);

        // Redirect beats a same-cycle load-use hazard
        rst = 1; tick(); rst = 0; tick();
        load_use_inputs(); redirect_ex = 1; #1;
        chk("rd_pc_we", {31'd0, pc_we3}, 1);
        chk("rd_nops", {29'd0, if_id_nop3, id_ex_nop3, ex_mem_nop3}, 3'b110);
        tick(); idle_inputs(); #1;
        chk("rd_flush", flush_cnt3, 1);
        chk("rd_stall", stall_cnt3, 0);
        chk("rd_no_stall_after", {31'd0, pc_we3}, 1);

        // Forwarding selects
        ex_rs1 = 3; ex_rs2 = 7; mem_rd = 3; wb_rd = 3; mem_we_reg = 1; wb_we_reg = 1; #1;
        chk("fwd_a_mem", {30'd0, fwd_a}, 2'b01);
        chk("fwd_b_none", {30'd0, fwd_b}, 2'b00);
        mem_we_reg = 0; #1;
        chk("fwd_a_wb", {30'd0, fwd_a}, 2'b10);
        ex_rs2 = 4; wb_rd = 4; mem_rd = 9; mem_we_reg = 1; #1;
        chk("fwd_b_wb", {30'd0, fwd_b}, 2'b10);
        ex_rs1 = 0; ex_rs2 = 0; mem_rd = 0; wb_rd = 0; #1;
        chk("fwd_x0", {28'd0, fwd_a, fwd_b}, 0);
        idle_inputs();

        // Halt: drain 3 cycles, halted visible 4 cycles after the halt cycle
        tick(); id_halt = 1; #1;
        chk("halt_pc_we", {31'd0, pc_we}, 0);
        chk("halt_id_ex_nop", {31'd0, id_ex_nop}, 1);
        tick(); idle_inputs();
        for (int i = 1; i <= 3; i++) begin
            #1;
            chk("drain_halted", {31'd0, halted}, 0);
            chk("drain_pc_we", {31'd0, pc_we}, 0);
            tick();
        end
        #1;
        chk("halted_rise", {31'd0, halted}, 1);
        chk("halted_pc_we", {31'd0, pc_we}, 0);
        redirect_ex = 1;
        tick(); redirect_ex = 0; #1;
        chk("halted_sticky", {31'd0, halted}, 1);
        chk("halted_ex_mem_nop", {31'd0, ex_mem_nop}, 1);

        // Reset mid-drain clears state and counters
        rst = 1; tick(); rst = 0;
        redirect_ex = 1; tick(); redirect_ex = 0;
        id_halt = 1; tick(); idle_inputs(); #1;
        chk("mid_drain_flush", flush_cnt, 1);
        chk("mid_drain_pc_we", {31'd0, pc_we}, 0);
        rst = 1; tick(); rst = 0; #1;
        chk("mid_rst_halted", {31'd0, halted}, 0);
        chk("mid_rst_flush", flush_cnt, 0);
        tick(); #1;
        chk("mid_rst_run", {31'd0, pc_we}, 1);
        tick(); tick(); tick(); #1;
        chk("mid_rst_no_halt", {31'd0, halted}, 0);

        // flush_count wraps at 2^32
        force u_dut.r_flush_count = 32'hFFFF_FFFF;
        #1 release u_dut.r_flush_count;
        #1;
        chk("wrap_preload", flush_cnt, 32'hFFFF_FFFF);
        redirect_ex = 1;
        tick(); redirect_ex = 0; #1;
        chk("wrap_zero", flush_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard bound on run time.
    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline control unit for the 5-stage RV32I core. It drives the we/nop inputs of the IF_ID, ID_EX and EX_MEM stage registers and the PC write enable. It resolves load-use stalls, EX-stage control-flow redirects and a drain-then-halt sequence. It also produces EX operand forwarding selects and two 32-bit performance counters.

Parameters:
LOAD_USE_STALL, 1, bubble cycles inserted per load-use hazard (valid range 1..7)
DRAIN_CYCLES, 3, cycles after a halt before halted asserts (valid range 1..7)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
id_rs1  in  5  rs1 of the instruction in ID
id_rs2  in  5  rs2 of the instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
id_halt  in  1  ID instruction is ECALL/EBREAK (halt request)
ex_rs1  in  5  rs1 of the instruction in EX
ex_rs2  in  5  rs2 of the instruction in EX
ex_rd  in  5  rd in EX
ex_we_reg  in  1  EX instruction writes the register file
ex_is_load  in  1  EX instruction is a load
redirect_ex  in  1  taken branch or JAL/JALR resolved in EX
mem_rd  in  5  rd in MEM
mem_we_reg  in  1  MEM instruction writes the register file
wb_rd  in  5  rd in WB
wb_we_reg  in  1  WB instruction writes the register file
pc_we  out  1  PC register load enable
if_id_we  out  1  IF_ID we
if_id_nop  out  1  IF_ID nop
id_ex_we  out  1  ID_EX we
id_ex_nop  out  1  ID_EX nop (bubble)
ex_mem_nop  out  1  EX_MEM nop (squash)
fwd_a_sel  out  2  EX operand A source: 00 RF, 01 EX_MEM result, 10 MEM_WB writeback value
fwd_b_sel  out  2  EX operand B source, same encoding as fwd_a_sel
halted  out  1  pipeline drained and stopped
stall_cycles  out  32  count of cycles with pc_we=0 in RUN/LOAD_STALL
flush_count  out  32  count of redirects taken

Behaviour:
- FSM states: RUN, LOAD_STALL, DRAIN, HALTED. There is a 3-bit down-counter cnt.
- rst high: state goes to RUN, cnt=0, halted=0, both counters=0. While rst is high the outputs are forced to pc_we=0, if_id_we=1, if_id_nop=1, id_ex_we=1, id_ex_nop=1, ex_mem_nop=1, fwd selects=00.
- lu_hazard = ex_is_load & ex_we_reg & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Priority in RUN: redirect_ex > lu_hazard > id_halt.
- RUN, no event: pc_we=1, if_id_we=1, if_id_nop=0, id_ex_we=1, id_ex_nop=0, ex_mem_nop=0.
- RUN with redirect_ex: pc_we=1, if_id_we=1, if_id_nop=1, id_ex_we=1, id_ex_nop=1. The EX instruction proceeds (ex_mem_nop=0). flush_count increments by 1. State stays RUN.
- RUN with lu_hazard: pc_we=0, if_id_we=0, id_ex_we=1, id_ex_nop=1. stall_cycles increments by 1. If LOAD_USE_STALL>1, go to LOAD_STALL with cnt=LOAD_USE_STALL-2; otherwise stay in RUN.
- LOAD_STALL: same outputs as the lu_hazard cycle. stall_cycles increments each cycle. When cnt==0 go to RUN, else decrement cnt. If redirect_ex is asserted, apply the redirect outputs and go to RUN with cnt=0.
- RUN with id_halt: the halt instruction is bubbled. pc_we=0, if_id_we=0, id_ex_we=1, id_ex_nop=1. Go to DRAIN with cnt=DRAIN_CYCLES-1.
- DRAIN: same outputs as the halt cycle. stall_cycles does not increment. When cnt==0 go to HALTED and set halted=1 from the next cycle; otherwise decrement cnt.
- HALTED: pc_we=0, if_id_we=0, id_ex_nop=1, ex_mem_nop=1, halted=1. Only rst exits HALTED.
- Forwarding is combinational, evaluated independently for rs1→A and rs2→B.
  - sel=01 if mem_we_reg & mem_rd!=0 & mem_rd==ex_rsX.
  - Else sel=10 if wb_we_reg & wb_rd!=0 & wb_rd==ex_rsX.
  - Else sel=00.
  - MEM has priority over WB when both match.
- Counters wrap at 2^32 with no saturation.
- All FSM and counter updates occur on the rising edge only.

Test Plan:
- Reset 2 cycles, then idle with no hazards → pc_we=1, all nop=0, fwd=00, halted=0, both counters=0.
- Load x5 in EX with ID add x6,x5,x1 (id_uses_rs1=1, id_rs1=5), LOAD_USE_STALL=1 → exactly 1 cycle with pc_we=0, if_id_we=0, id_ex_nop=1. Same stimulus with LOAD_USE_STALL=3 → 3 such cycles; stall_cycles=1 and 3 respectively.
- Same-cycle redirect_ex=1 and lu_hazard=1 → redirect outputs (pc_we=1, if_id_nop=1, id_ex_nop=1), no stall; flush_count=1, stall_cycles=0.
- ex_rs1=3 with mem_rd=3, wb_rd=3, both we=1 → fwd_a_sel=01. With mem_we_reg=0 → 10. With ex_rs1=0 and all rd=0 → 00.
- id_halt=1, DRAIN_CYCLES=3 → halted rises exactly 4 cycles after the halt cycle and pc_we stays 0. Asserting rst mid-DRAIN → RUN, halted=0, counters cleared.
- Preload flush_count by issuing redirects and force a wrap at 0xFFFFFFFF → next redirect yields 0.
